// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier sequencer that borrows the CPU's single 32-bit ALU.
// While idle, the ALU is a straight bypass of the CPU controls. While busy, the FSM owns the ALU and the CPU stalls.
module alu_mul_sequencer #(
  parameter int ITER_MAX   = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] byp_a,
  input  logic [31:0] byp_b,
  input  logic [5:0]  byp_fun,
  input  logic        byp_sign,
  input  logic [31:0] alu_s,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_fun,
  output logic        alu_sign,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADD  = 3'd1;
  localparam logic [2:0] S_SHL  = 3'd2;
  localparam logic [2:0] S_SHR  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [5:0] FUN_ADD = 6'b000000;
  localparam logic [5:0] FUN_SLL = 6'b100000;
  localparam logic [5:0] FUN_SRL = 6'b100001;

  localparam logic [5:0] ITER_LAST = 6'(ITER_MAX);

  logic [2:0]  r_state;
  logic [2:0]  w_nextState;
  logic [31:0] r_acc;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_result;
  logic [5:0]  r_cnt;
  logic [5:0]  w_cntNext;
  logic        w_lastIter;

  // In SHR, alu_s is the multiplier after the shift, so an all-zero result means no set bits remain.
  assign w_cntNext  = r_cnt + 6'd1;
  assign w_lastIter = (w_cntNext == ITER_LAST) || (EARLY_EXIT && (alu_s == 32'd0));

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nextState = S_ADD;
      S_ADD:   w_nextState = S_SHL;
      S_SHL:   w_nextState = S_SHR;
      S_SHR:   w_nextState = w_lastIter ? S_DONE : S_ADD;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_nextState;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc    <= 32'd0;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_cnt    <= 6'd0;
      r_result <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= op_a;
            r_mplier <= op_b;
            r_acc    <= 32'd0;
            r_cnt    <= 6'd0;
          end
        end
        S_ADD: begin
          if (r_mplier[0]) r_acc <= alu_s;
        end
        S_SHL: begin
          r_mcand <= alu_s;
        end
        S_SHR: begin
          r_mplier <= alu_s;
          r_cnt    <= w_cntNext;
          if (w_lastIter) r_result <= r_acc;
        end
        default: ;
      endcase
    end
  end

  // Bypass is the default, so the CPU regains the ALU in the same cycle the FSM returns to idle or is reset.
  always_comb begin
    alu_a    = byp_a;
    alu_b    = byp_b;
    alu_fun  = byp_fun;
    alu_sign = byp_sign;
    case (r_state)
      S_ADD: begin
        alu_a    = r_acc;
        alu_b    = r_mcand;
        alu_fun  = FUN_ADD;
        alu_sign = 1'b0;
      end
      S_SHL: begin
        alu_a    = 32'd1;
        alu_b    = r_mcand;
        alu_fun  = FUN_SLL;
        alu_sign = 1'b0;
      end
      S_SHR: begin
        alu_a    = 32'd1;
        alu_b    = r_mplier;
        alu_fun  = FUN_SRL;
        alu_sign = 1'b0;
      end
      S_DONE: begin
        alu_a    = 32'd0;
        alu_b    = 32'd0;
        alu_fun  = FUN_ADD;
        alu_sign = 1'b0;
      end
      default: ;
    endcase
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: one early-exit and one full-iteration instance.
// Both instances share the stimulus, and each has its own behavioural ALU.
module tb_alu_mul_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] byp_a;
  logic [31:0] byp_b;
  logic [5:0]  byp_fun;
  logic        byp_sign;

  logic [31:0] aluSE, aluAE, aluBE, resultE;
  logic [5:0]  aluFunE;
  logic        aluSignE, busyE, doneE;
  logic [31:0] aluSF, aluAF, aluBF, resultF;
  logic [5:0]  aluFunF;
  logic        aluSignF, busyF, doneF;

  int checkCount = 0;
  int errorCount = 0;

  function automatic logic [31:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [5:0] fun);
    case (fun)
      6'b000000: aluModel = a + b;
      6'b100000: aluModel = b << a[4:0];
      6'b100001: aluModel = b >> a[4:0];
      default:   aluModel = 32'hDEADBEEF;
    endcase
  endfunction

  assign aluSE = aluModel(aluAE, aluBE, aluFunE);
  assign aluSF = aluModel(aluAF, aluBF, aluFunF);

  alu_mul_sequencer #(.ITER_MAX(32), .EARLY_EXIT(1'b1)) dutEarly (
    .clk(clk), .reset_n(reset_n), .start(start), .op_a(op_a), .op_b(op_b),
    .byp_a(byp_a), .byp_b(byp_b), .byp_fun(byp_fun), .byp_sign(byp_sign),
    .alu_s(aluSE), .alu_a(aluAE), .alu_b(aluBE), .alu_fun(aluFunE), .alu_sign(aluSignE),
    .busy(busyE), .done(doneE), .result(resultE)
  );

  alu_mul_sequencer #(.ITER_MAX(32), .EARLY_EXIT(1'b0)) dutFull (
    .clk(clk), .reset_n(reset_n), .start(start), .op_a(op_a), .op_b(op_b),
    .byp_a(byp_a), .byp_b(byp_b), .byp_fun(byp_fun), .byp_sign(byp_sign),
    .alu_s(aluSF), .alu_a(aluAF), .alu_b(aluBF), .alu_fun(aluFunF), .alu_sign(aluSignF),
    .busy(busyF), .done(doneF), .result(resultF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Cycle 0 is the cycle in which start is high. Done cycles, results and pulse counts are recorded for both instances.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input int latE, input int latF, input logic [31:0] expResult,
                               input bit glitch, input bit checkAlu);
    int gotLatE = 0, gotLatF = 0, pulsesE = 0, pulsesF = 0;
    logic [31:0] resE = 32'hX, resF = 32'hX;
    logic afterE = 1'bX;
    logic [5:0] funSeq [1:3];
    logic [31:0] shlA = 32'h0, shlB = 32'h0;
    logic signSeen = 1'b0;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk); #1;
    start = 1'b0;
    op_a  = 32'h0BAD0BAD;
    op_b  = 32'h0000FFFF;
    for (int n = 1; n <= 110; n++) begin
      if (n == 1) begin
        checkOutput({tag, "_busyE_c1"}, {31'd0, busyE}, 32'd1);
        checkOutput({tag, "_busyF_c1"}, {31'd0, busyF}, 32'd1);
      end
      if (n <= 3) begin
        funSeq[n] = aluFunE;
        signSeen  = signSeen | aluSignE;
      end
      if (n == 2) begin
        shlA = aluAE;
        shlB = aluBE;
      end
      if (doneE) pulsesE++;
      if (doneF) pulsesF++;
      if (doneE && gotLatE == 0) begin
        gotLatE = n;
        resE    = resultE;
      end
      if (doneF && gotLatF == 0) begin
        gotLatF = n;
        resF    = resultF;
      end
      if (gotLatE != 0 && n == gotLatE + 1) afterE = busyE;
      if (glitch && n == 4) begin
        start = 1'b1;
        op_a  = 32'd100;
        op_b  = 32'd100;
      end
      if (glitch && n == 5) start = 1'b0;
      @(posedge clk); #1;
    end
    checkOutput({tag, "_latE"}, gotLatE, latE);
    checkOutput({tag, "_resE"}, resE, expResult);
    checkOutput({tag, "_busyAfterE"}, {31'd0, afterE}, 32'd0);
    checkOutput({tag, "_pulsesE"}, pulsesE, 32'd1);
    checkOutput({tag, "_latF"}, gotLatF, latF);
    checkOutput({tag, "_resF"}, resF, expResult);
    checkOutput({tag, "_pulsesF"}, pulsesF, 32'd1);
    checkOutput({tag, "_heldE"}, resultE, expResult);
    if (checkAlu) begin
      checkOutput({tag, "_funAdd"}, {26'd0, funSeq[1]}, 32'h00);
      checkOutput({tag, "_funSll"}, {26'd0, funSeq[2]}, 32'h20);
      checkOutput({tag, "_funSrl"}, {26'd0, funSeq[3]}, 32'h21);
      checkOutput({tag, "_signBusy"}, {31'd0, signSeen}, 32'd0);
      checkOutput({tag, "_shlA"}, shlA, 32'd1);
      checkOutput({tag, "_shlB"}, shlB, a);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    op_a     = 32'd0;
    op_b     = 32'd0;
    byp_a    = 32'd7;
    byp_b    = 32'd9;
    byp_fun  = 6'd0;
    byp_sign = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'd0, busyE}, 32'd0);
    checkOutput("rst_done", {31'd0, doneE}, 32'd0);
    checkOutput("rst_result", resultE, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    checkOutput("byp_a", aluAE, 32'd7);
    checkOutput("byp_b", aluBE, 32'd9);
    checkOutput("byp_fun", {26'd0, aluFunE}, 32'd0);
    checkOutput("byp_sign", {31'd0, aluSignE}, 32'd1);
    byp_a   = 32'hA5A5_0001;
    byp_fun = 6'h33;
    #1;
    checkOutput("byp_a2", aluAE, 32'hA5A5_0001);
    checkOutput("byp_fun2", {26'd0, aluFunE}, 32'h33);

    $display("[TB] case 1: 3*5 with stray start while busy");
    applyStimulus("c1", 32'd3, 32'd5, 10, 97, 32'd15, 1'b1, 1'b1);
    $display("[TB] case 2: all ones squared");
    applyStimulus("c2", 32'hFFFFFFFF, 32'hFFFFFFFF, 97, 97, 32'h00000001, 1'b0, 1'b0);
    $display("[TB] case 3: zero multiplier");
    applyStimulus("c3", 32'h1234, 32'd0, 4, 97, 32'd0, 1'b0, 1'b0);
    $display("[TB] case 4: -7*3");
    applyStimulus("c4", 32'hFFFFFFF9, 32'd3, 7, 97, 32'hFFFFFFEB, 1'b0, 1'b0);

    $display("[TB] case 6: reset mid-operation");
    start = 1'b1;
    op_a  = 32'd3;
    op_b  = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("rstMid_busyBefore", {31'd0, busyE}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("rstMid_busyE", {31'd0, busyE}, 32'd0);
    checkOutput("rstMid_doneE", {31'd0, doneE}, 32'd0);
    checkOutput("rstMid_resultE", resultE, 32'd0);
    checkOutput("rstMid_busyF", {31'd0, busyF}, 32'd0);
    checkOutput("rstMid_resultF", resultF, 32'd0);
    checkOutput("rstMid_bypA", aluAE, byp_a);
    checkOutput("rstMid_bypFun", {26'd0, aluFunE}, {26'd0, byp_fun});
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus("c6", 32'd3, 32'd5, 10, 97, 32'd15, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
